// File: rtl/periph_pkg.sv
// Shared constants and page encoding for the memory-mapped output peripheral.
// Decode is addr[31:16] for the window, then addr[15:12] for the page.
package periph_pkg;

  localparam logic [15:0] BASE_HI = 16'h1000;
  localparam logic [15:0] SW_HI   = 16'h1001;

  typedef enum logic [3:0] {
    PAGE_LEDR,
    PAGE_LEDG,
    PAGE_HEXL,
    PAGE_HEXH,
    PAGE_LCD
  } page_e;

  localparam logic [6:0]  HEX_BLANK     = 7'h7F;
  localparam logic [31:0] HEX_WORD_RST  = {4{1'b0, HEX_BLANK}};
  // Bit 7 of every HEX byte is not storage; it is cleared before the register sees it.
  localparam logic [31:0] HEX_WORD_MASK = 32'h7F7F_7F7F;

endpackage

// File: rtl/byte_mask_reg.sv
// One 32-bit register with per-byte write enables and a parameterised reset value.
// Bytes whose enable is low keep their contents.
module byte_mask_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  bmask,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (we) begin
      for (int n = 0; n < 4; n++) begin
        if (bmask[n]) q[8*n +: 8] <= wdata[8*n +: 8];
      end
    end
  end

endmodule

// File: rtl/output_periph.sv
// Memory-mapped board I/O: LED, seven-segment and LCD registers written by stores,
// plus a synchronised switch word, all readable through a 1-cycle load port.
module output_periph #(
  parameter int          SW_SYNC_STAGES = 2,
  parameter logic [15:0] BASE_HI        = periph_pkg::BASE_HI,
  parameter logic [15:0] SW_HI          = periph_pkg::SW_HI
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_st_en,
  input  logic        i_ld_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_bmask,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);
  import periph_pkg::*;

  logic [15:0] addr_hi;
  logic [3:0]  addr_pg;
  logic        base_hit;
  logic        sw_hit;
  logic [4:0]  we;
  logic [31:0] ledr_q, ledg_q, hexl_q, hexh_q, lcd_q;
  logic [31:0] rd_mux;
  logic [31:0] sw_sync [SW_SYNC_STAGES];
  logic        addr_lo_unused;

  // addr[11:0] is deliberately ignored so each register mirrors across its page.
  assign addr_lo_unused = ^i_addr[11:0];

  assign addr_hi  = i_addr[31:16];
  assign addr_pg  = i_addr[15:12];
  assign base_hit = (addr_hi == BASE_HI);
  assign sw_hit   = (addr_hi == SW_HI) && (addr_pg == 4'h0);

  always_comb begin
    we = '0;
    if (i_st_en && base_hit) begin
      case (page_e'(addr_pg))
        PAGE_LEDR: we[0] = 1'b1;
        PAGE_LEDG: we[1] = 1'b1;
        PAGE_HEXL: we[2] = 1'b1;
        PAGE_HEXH: we[3] = 1'b1;
        PAGE_LCD:  we[4] = 1'b1;
        default:   we    = '0;
      endcase
    end
  end

  byte_mask_reg #(.RESET_VAL(32'h0)) u_ledr (
    .clk(i_clk), .reset(i_reset), .we(we[0]), .bmask(i_bmask),
    .wdata(i_wdata), .q(ledr_q)
  );

  byte_mask_reg #(.RESET_VAL(32'h0)) u_ledg (
    .clk(i_clk), .reset(i_reset), .we(we[1]), .bmask(i_bmask),
    .wdata(i_wdata), .q(ledg_q)
  );

  byte_mask_reg #(.RESET_VAL(HEX_WORD_RST)) u_hexl (
    .clk(i_clk), .reset(i_reset), .we(we[2]), .bmask(i_bmask),
    .wdata(i_wdata & HEX_WORD_MASK), .q(hexl_q)
  );

  byte_mask_reg #(.RESET_VAL(HEX_WORD_RST)) u_hexh (
    .clk(i_clk), .reset(i_reset), .we(we[3]), .bmask(i_bmask),
    .wdata(i_wdata & HEX_WORD_MASK), .q(hexh_q)
  );

  byte_mask_reg #(.RESET_VAL(32'h0)) u_lcd (
    .clk(i_clk), .reset(i_reset), .we(we[4]), .bmask(i_bmask),
    .wdata(i_wdata), .q(lcd_q)
  );

  // Switch pins are asynchronous; only the last stage is ever read.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < SW_SYNC_STAGES; i++) sw_sync[i] <= '0;
    end else begin
      sw_sync[0] <= i_io_sw;
      for (int i = 1; i < SW_SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  // Mux reads the registers' current contents, so a same-cycle store is not visible.
  always_comb begin
    rd_mux = '0;
    if (base_hit) begin
      case (page_e'(addr_pg))
        PAGE_LEDR: rd_mux = ledr_q;
        PAGE_LEDG: rd_mux = ledg_q;
        PAGE_HEXL: rd_mux = hexl_q;
        PAGE_HEXH: rd_mux = hexh_q;
        PAGE_LCD:  rd_mux = lcd_q;
        default:   rd_mux = '0;
      endcase
    end else if (sw_hit) begin
      rd_mux = sw_sync[SW_SYNC_STAGES-1];
    end
  end

  // Load handshake: no ready, every i_ld_en accepted; o_rvalid pulses for exactly
  // the cycle after the strobe, and o_rdata holds its last value when o_rvalid is low.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= i_ld_en;
      if (i_ld_en) o_rdata <= rd_mux;
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex0 = hexl_q[6:0];
  assign o_io_hex1 = hexl_q[14:8];
  assign o_io_hex2 = hexl_q[22:16];
  assign o_io_hex3 = hexl_q[30:24];
  assign o_io_hex4 = hexh_q[6:0];
  assign o_io_hex5 = hexh_q[14:8];
  assign o_io_hex6 = hexh_q[22:16];
  assign o_io_hex7 = hexh_q[30:24];

endmodule

// File: tb/tb_output_periph.sv
// Directed table-driven bench for output_periph: store/load vectors with hand-computed
// expectations, a load scoreboard, and hand-written switch-sync and reset sequences.
module tb_output_periph;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_en, ld_en;
  logic [31:0] addr, wdata;
  logic [3:0]  bmask;
  logic [31:0] rdata;
  logic        rvalid;
  logic [31:0] io_sw;
  logic [31:0] ledr, ledg, lcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        st;
    logic        ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] rdata;
    logic [31:0] ledr;
    logic [31:0] ledg;
    logic [31:0] hexl;
    logic [31:0] hexh;
    logic [31:0] lcd;
  } vec_t;

  vec_t vecs[$];

  output_periph dut (
    .i_clk(clk), .i_reset(reset), .i_st_en(st_en), .i_ld_en(ld_en),
    .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
    .o_rdata(rdata), .o_rvalid(rvalid), .i_io_sw(io_sw),
    .o_io_ledr(ledr), .o_io_ledg(ledg),
    .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
    .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7),
    .o_io_lcd(lcd)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] hexl_word();
    return {1'b0, hex3, 1'b0, hex2, 1'b0, hex1, 1'b0, hex0};
  endfunction

  function automatic logic [31:0] hexh_word();
    return {1'b0, hex7, 1'b0, hex6, 1'b0, hex5, 1'b0, hex4};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] e_rdata, input logic e_rvalid,
                          input logic [31:0] e_ledr, input logic [31:0] e_ledg,
                          input logic [31:0] e_hexl, input logic [31:0] e_hexh,
                          input logic [31:0] e_lcd);
    chk({tag, ".rvalid"}, {31'h0, rvalid}, {31'h0, e_rvalid});
    chk({tag, ".rdata"},  rdata,       e_rdata);
    chk({tag, ".ledr"},   ledr,        e_ledr);
    chk({tag, ".ledg"},   ledg,        e_ledg);
    chk({tag, ".hexl"},   hexl_word(), e_hexl);
    chk({tag, ".hexh"},   hexh_word(), e_hexh);
    chk({tag, ".lcd"},    lcd,         e_lcd);
  endtask

  // driver: present one cycle of strobes, clock it, sample 1 time unit after the edge
  task automatic drive(input logic st, input logic ld, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    st_en = st; ld_en = ld; addr = a; wdata = d; bmask = m;
    @(posedge clk);
    #1;
    st_en = 1'b0; ld_en = 1'b0;
  endtask

  // scoreboard: every observed rvalid pops the oldest expected load value
  task automatic sb_check(input string tag);
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".sb_unexpected_rvalid"}, 32'h1, 32'h0);
      end else begin
        chk({tag, ".sb"}, rdata, exp_q.pop_front());
      end
    end
  endtask

  function automatic vec_t mk(input logic st, input logic ld, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m,
                              input logic [31:0] rd, input logic [31:0] e_ledr,
                              input logic [31:0] e_ledg, input logic [31:0] e_hexl,
                              input logic [31:0] e_hexh, input logic [31:0] e_lcd);
    vec_t v;
    v.st = st; v.ld = ld; v.addr = a; v.wdata = d; v.bmask = m;
    v.rdata = rd; v.ledr = e_ledr; v.ledg = e_ledg;
    v.hexl = e_hexl; v.hexh = e_hexh; v.lcd = e_lcd;
    return v;
  endfunction

  initial begin
    localparam logic [31:0] B = 32'h7F7F_7F7F;
    reset = 1'b1; st_en = 1'b0; ld_en = 1'b0;
    addr = '0; wdata = '0; bmask = '0; io_sw = '0;

    //          st ld addr          wdata         mask     rdata         ledr   ledg          hexl          hexh          lcd
    vecs.push_back(mk(1, 0, 32'h1000_0000, 32'h0000_0001, 4'b1111, 32'h0,         32'h1, 32'h0,         B,            B,            32'h0));
    vecs.push_back(mk(0, 1, 32'h1000_0000, 32'h0,         4'b0000, 32'h1,         32'h1, 32'h0,         B,            B,            32'h0));
    vecs.push_back(mk(1, 0, 32'h1000_1000, 32'hAABB_CCDD, 4'b1111, 32'h1,         32'h1, 32'hAABB_CCDD, B,            B,            32'h0));
    vecs.push_back(mk(1, 0, 32'h1000_1000, 32'h0000_EE00, 4'b0010, 32'h1,         32'h1, 32'hAABB_EEDD, B,            B,            32'h0));
    vecs.push_back(mk(0, 1, 32'h1000_1ABC, 32'h0,         4'b0000, 32'hAABB_EEDD, 32'h1, 32'hAABB_EEDD, B,            B,            32'h0));
    vecs.push_back(mk(1, 0, 32'h1000_1000, 32'hFFFF_FFFF, 4'b0000, 32'hAABB_EEDD, 32'h1, 32'hAABB_EEDD, B,            B,            32'h0));
    vecs.push_back(mk(1, 0, 32'h1000_3004, 32'hC0F9_A4B0, 4'b1111, 32'hAABB_EEDD, 32'h1, 32'hAABB_EEDD, B,            32'h4079_2430, 32'h0));
    vecs.push_back(mk(0, 1, 32'h1000_3000, 32'h0,         4'b0000, 32'h4079_2430, 32'h1, 32'hAABB_EEDD, B,            32'h4079_2430, 32'h0));
    vecs.push_back(mk(1, 0, 32'h1000_2000, 32'h0,         4'b0101, 32'h4079_2430, 32'h1, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h0));
    vecs.push_back(mk(0, 1, 32'h1000_2FFC, 32'h0,         4'b0000, 32'h7F00_7F00, 32'h1, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h0));
    vecs.push_back(mk(1, 0, 32'h1000_4000, 32'h1234_5678, 4'b1100, 32'h7F00_7F00, 32'h1, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h1234_0000));
    // same-cycle store and load on LEDR: load sees the old value
    vecs.push_back(mk(1, 1, 32'h1000_0000, 32'h0,         4'b1111, 32'h1,         32'h0, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h1234_0000));
    // dropped stores: switch window, foreign window, unmapped page
    vecs.push_back(mk(1, 0, 32'h1001_0000, 32'hFFFF_FFFF, 4'b1111, 32'h1,         32'h0, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h1234_0000));
    vecs.push_back(mk(1, 0, 32'h2000_0000, 32'hFFFF_FFFF, 4'b1111, 32'h1,         32'h0, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h1234_0000));
    vecs.push_back(mk(1, 0, 32'h1000_5000, 32'hFFFF_FFFF, 4'b1111, 32'h1,         32'h0, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h1234_0000));
    vecs.push_back(mk(0, 1, 32'h2000_0000, 32'h0,         4'b0000, 32'h0,         32'h0, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h1234_0000));
    vecs.push_back(mk(0, 1, 32'h1000_4800, 32'h0,         4'b0000, 32'h1234_0000, 32'h0, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h1234_0000));
    vecs.push_back(mk(0, 1, 32'h1001_1000, 32'h0,         4'b0000, 32'h0,         32'h0, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h1234_0000));
    vecs.push_back(mk(0, 1, 32'h1000_5000, 32'h0,         4'b0000, 32'h0,         32'h0, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h1234_0000));
    vecs.push_back(mk(0, 1, 32'h1001_0000, 32'h0,         4'b0000, 32'h0,         32'h0, 32'hAABB_EEDD, 32'h7F00_7F00, 32'h4079_2430, 32'h1234_0000));

    // reset for 3 cycles, with a load pending to show it is lost
    ld_en = 1'b1; addr = 32'h1000_0000;
    repeat (3) @(posedge clk);
    #1;
    ld_en = 1'b0;
    chk_outs("reset", 32'h0, 1'b0, 32'h0, 32'h0, B, B, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].ld) exp_q.push_back(vecs[i].rdata);
      drive(vecs[i].st, vecs[i].ld, vecs[i].addr, vecs[i].wdata, vecs[i].bmask);
      sb_check($sformatf("vec%0d", i));
      chk_outs($sformatf("vec%0d", i), vecs[i].rdata, vecs[i].ld,
               vecs[i].ledr, vecs[i].ledg, vecs[i].hexl, vecs[i].hexh, vecs[i].lcd);
    end

    // switch synchroniser: loads see the pin only after two stages
    io_sw = 32'h0000_0155;
    drive(0, 1, 32'h1001_0000, 32'h0, 4'b0000);
    chk("sw_lat1", rdata, 32'h0);
    drive(0, 1, 32'h1001_0000, 32'h0, 4'b0000);
    chk("sw_lat2", rdata, 32'h0);
    drive(0, 1, 32'h1001_0000, 32'h0, 4'b0000);
    chk("sw_lat3", rdata, 32'h0000_0155);
    chk("sw_lat3.rvalid", {31'h0, rvalid}, 32'h1);

    // reset in the middle of activity: store and load in the reset cycle are lost
    reset = 1'b1;
    drive(1, 1, 32'h1000_0000, 32'hDEAD_BEEF, 4'b1111);
    chk_outs("midreset", 32'h0, 1'b0, 32'h0, 32'h0, B, B, 32'h0);
    reset = 1'b0;
    // synchroniser was cleared, so the first load after reset still reads 0
    drive(0, 1, 32'h1001_0000, 32'h0, 4'b0000);
    chk("post_reset_sw", rdata, 32'h0);
    chk("post_reset_rvalid", {31'h0, rvalid}, 32'h1);

    drive(0, 0, 32'h0, 32'h0, 4'b0000);
    chk("idle.rvalid", {31'h0, rvalid}, 32'h0);
    chk("idle.rdata_hold", rdata, 32'h0);
    chk("sb_drain", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
